// File: rtl/OoO_pkg.sv
// Shared core types: AXI read-channel structs and the read-port arbiter's
// state encoding and requester indices.
package OoO_pkg;

  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiIdW   = 4;

  // Requester-to-memory direction: AR request plus R ready.
  typedef struct packed {
    logic                arvalid;
    logic [AxiAddrW-1:0] araddr;
    logic [AxiIdW-1:0]   arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                rready;
  } axi_r_m2s_t;

  // Memory-to-requester direction: AR ready plus R beat.
  typedef struct packed {
    logic                arready;
    logic                rvalid;
    logic [AxiDataW-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [AxiIdW-1:0]   rid;
  } axi_r_s2m_t;

  // AR payload held while the request waits for the memory side.
  typedef struct packed {
    logic [AxiAddrW-1:0] addr;
    logic [AxiIdW-1:0]   id;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_ar_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  localparam logic ReqIfu = 1'b0;
  localparam logic ReqLsu = 1'b1;

  function automatic axi_ar_t ar_from_req(input axi_r_m2s_t m);
    axi_ar_t ar;
    ar.addr  = m.araddr;
    ar.id    = m.arid;
    ar.len   = m.arlen;
    ar.size  = m.arsize;
    ar.burst = m.arburst;
    return ar;
  endfunction

endpackage

// File: rtl/axi_r_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to prio.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    gnt_idx = 1'b0;
    gnt     = 2'b00;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio;
      default: gnt_idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_r_arbiter.sv
// Shares the single AXI read port between IFU (requester 0) and LSU (requester 1).
// One read in flight; an IFU flush sinks the rest of an IFU read at the memory side.
module axi_r_arbiter
  import OoO_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ifu_flush,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  output axi_r_m2s_t mem_r_m2s,
  input  axi_r_s2m_t mem_r_s2m,
  output logic       busy,
  output logic       owner
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       prio_q, prio_d;
  logic       drop_q, drop_d;
  axi_ar_t    ar_q, ar_d;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_idx;

  logic       owner_is_ifu;
  logic       flush_owned;
  logic       drop_now;
  logic       owner_rready;
  logic       data_rready;
  logic       last_hs;
  axi_r_s2m_t owner_resp;

  assign arb_req = {lsu_r_m2s.arvalid, ifu_r_m2s.arvalid & ~ifu_flush};

  rr_arb2 u_rr_arb2 (
    .req     (arb_req),
    .prio    (prio_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign owner_is_ifu = (owner_q == ReqIfu);
  assign flush_owned  = ifu_flush & owner_is_ifu;
  // A flush arriving in the same cycle as a beat already hides that beat.
  assign drop_now     = drop_q | flush_owned;
  assign owner_rready = owner_is_ifu ? ifu_r_m2s.rready : lsu_r_m2s.rready;
  assign data_rready  = drop_now | owner_rready;
  assign last_hs      = (state_q == DATA) & mem_r_s2m.rvalid & data_rready
                        & mem_r_s2m.rlast;

  always_comb begin
    owner_resp         = mem_r_s2m;
    owner_resp.arready = 1'b0;
    owner_resp.rvalid  = mem_r_s2m.rvalid & ~drop_now;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    drop_d  = drop_q;
    ar_d    = ar_q;

    ifu_r_s2m = '0;
    lsu_r_s2m = '0;

    mem_r_m2s         = '0;
    mem_r_m2s.araddr  = ar_q.addr;
    mem_r_m2s.arid    = ar_q.id;
    mem_r_m2s.arlen   = ar_q.len;
    mem_r_m2s.arsize  = ar_q.size;
    mem_r_m2s.arburst = ar_q.burst;

    case (state_q)
      IDLE: begin
        ifu_r_s2m.arready = arb_gnt[0];
        lsu_r_s2m.arready = arb_gnt[1];
        if (arb_gnt != 2'b00) begin
          state_d = ADDR;
          owner_d = arb_idx;
          ar_d    = (arb_idx == ReqLsu) ? ar_from_req(lsu_r_m2s)
                                        : ar_from_req(ifu_r_m2s);
        end
      end

      ADDR: begin
        mem_r_m2s.arvalid = 1'b1;
        if (flush_owned) begin
          drop_d = 1'b1;
        end
        if (mem_r_s2m.arready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        mem_r_m2s.rready = data_rready;
        if (owner_is_ifu) begin
          ifu_r_s2m = owner_resp;
        end else begin
          lsu_r_s2m = owner_resp;
        end
        if (flush_owned) begin
          drop_d = 1'b1;
        end
        if (last_hs) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
          drop_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= ReqIfu;
      prio_q  <= ReqIfu;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: ar_q is a data register with no reset: it is only observed in ADDR,
  // and it is always loaded on the IDLE->ADDR transition.
  always_ff @(posedge clock) begin
    ar_q <= ar_d;
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Self-checking bench for axi_r_arbiter: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_axi_r_arbiter;
  import OoO_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       ifu_flush;
  axi_r_m2s_t ifu_m2s, lsu_m2s, mem_m2s;
  axi_r_s2m_t ifu_s2m, lsu_s2m, mem_s2m;
  logic       busy, owner;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Transaction-level model: is a read open, has its AR reached memory,
  // who owns it, whose turn on a tie, and whether the owner's data is discarded.
  bit         m_busy  = 1'b0;
  bit         m_sent  = 1'b0;
  bit         m_owner = 1'b0;
  bit         m_turn  = 1'b0;
  bit         m_drop  = 1'b0;
  axi_r_m2s_t m_ar    = '0;

  int beats = 0;
  int gr_who[4];
  int gr_cyc[4];
  int ngr;

  axi_r_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .ifu_flush (ifu_flush),
    .ifu_r_m2s (ifu_m2s),
    .ifu_r_s2m (ifu_s2m),
    .lsu_r_m2s (lsu_m2s),
    .lsu_r_s2m (lsu_s2m),
    .mem_r_m2s (mem_m2s),
    .mem_r_s2m (mem_s2m),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs are derived from the current inputs and the model, then
  // the model advances as if the upcoming edge had happened.
  always @(negedge clock) begin
    axi_r_s2m_t e_ifu, e_lsu, fwd;
    bit e_arvalid, e_rready, ifu_req, lsu_req, sinking, own_rdy;
    int win;
    if (chk_en) begin
      e_ifu = '0;
      e_lsu = '0;
      e_arvalid = 1'b0;
      e_rready  = 1'b0;
      win = -1;
      ifu_req = ifu_m2s.arvalid && !ifu_flush;
      lsu_req = lsu_m2s.arvalid;
      if (!m_busy) begin
        if (ifu_req && lsu_req) win = m_turn ? 1 : 0;
        else if (ifu_req)       win = 0;
        else if (lsu_req)       win = 1;
        e_ifu.arready = (win == 0);
        e_lsu.arready = (win == 1);
      end else if (!m_sent) begin
        e_arvalid = 1'b1;
      end else begin
        sinking  = m_drop || (ifu_flush && !m_owner);
        own_rdy  = m_owner ? lsu_m2s.rready : ifu_m2s.rready;
        e_rready = sinking || own_rdy;
        fwd = mem_s2m;
        fwd.arready = 1'b0;
        fwd.rvalid  = mem_s2m.rvalid && !sinking;
        if (m_owner) e_lsu = fwd;
        else         e_ifu = fwd;
      end

      check("busy", 64'(busy), 64'(m_busy));
      if (m_busy) check("owner", 64'(owner), 64'(m_owner));
      check("mem_arvalid", 64'(mem_m2s.arvalid), 64'(e_arvalid));
      check("mem_rready", 64'(mem_m2s.rready), 64'(e_rready));
      if (e_arvalid) begin
        check("mem_araddr", 64'(mem_m2s.araddr), 64'(m_ar.araddr));
        check("mem_arid", 64'(mem_m2s.arid), 64'(m_ar.arid));
        check("mem_arlen", 64'(mem_m2s.arlen), 64'(m_ar.arlen));
        check("mem_arsize", 64'(mem_m2s.arsize), 64'(m_ar.arsize));
        check("mem_arburst", 64'(mem_m2s.arburst), 64'(m_ar.arburst));
      end
      check("ifu_arready", 64'(ifu_s2m.arready), 64'(e_ifu.arready));
      check("lsu_arready", 64'(lsu_s2m.arready), 64'(e_lsu.arready));
      check("ifu_rvalid", 64'(ifu_s2m.rvalid), 64'(e_ifu.rvalid));
      check("lsu_rvalid", 64'(lsu_s2m.rvalid), 64'(e_lsu.rvalid));
      if (e_ifu.rvalid) check("ifu_rbeat", 64'({ifu_s2m.rdata, ifu_s2m.rresp, ifu_s2m.rlast, ifu_s2m.rid}),
                              64'({e_ifu.rdata, e_ifu.rresp, e_ifu.rlast, e_ifu.rid}));
      if (e_lsu.rvalid) check("lsu_rbeat", 64'({lsu_s2m.rdata, lsu_s2m.rresp, lsu_s2m.rlast, lsu_s2m.rid}),
                              64'({e_lsu.rdata, e_lsu.rresp, e_lsu.rlast, e_lsu.rid}));

      if (reset) begin
        m_busy = 1'b0; m_sent = 1'b0; m_owner = 1'b0; m_turn = 1'b0; m_drop = 1'b0;
      end else if (!m_busy) begin
        if (win >= 0) begin
          m_busy  = 1'b1;
          m_sent  = 1'b0;
          m_owner = (win == 1);
          m_ar    = (win == 1) ? lsu_m2s : ifu_m2s;
        end
      end else begin
        if (ifu_flush && !m_owner) m_drop = 1'b1;
        if (!m_sent) begin
          if (mem_s2m.arready) m_sent = 1'b1;
        end else if (mem_s2m.rvalid && e_rready && mem_s2m.rlast) begin
          m_busy = 1'b0;
          m_turn = !m_owner;
          m_drop = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_flush = 1'b0;
    ifu_m2s   = '0;
    lsu_m2s   = '0;
    mem_s2m   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_arvalid"}, 64'(mem_m2s.arvalid), 64'(0));
    check({tag, "_mem_rready"}, 64'(mem_m2s.rready), 64'(0));
    check({tag, "_ifu_arready"}, 64'(ifu_s2m.arready), 64'(0));
    check({tag, "_lsu_arready"}, 64'(lsu_s2m.arready), 64'(0));
    check({tag, "_ifu_rvalid"}, 64'(ifu_s2m.rvalid), 64'(0));
    check({tag, "_lsu_rvalid"}, 64'(lsu_s2m.rvalid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_owner"}, 64'(owner), 64'(0));
  endtask

  function automatic axi_r_m2s_t rand_req();
    axi_r_m2s_t r;
    r.arvalid = 1'($urandom_range(0, 1));
    r.araddr  = $urandom;
    r.arid    = 4'($urandom_range(0, 15));
    r.arlen   = 8'($urandom_range(0, 3));
    r.arsize  = 3'($urandom_range(0, 2));
    r.arburst = 2'($urandom_range(0, 2));
    r.rready  = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    chk_en = 1'b1;
    at_mid();
    check_reset_outputs("por");
    next_cycle();
    reset = 1'b0;

    // Solo IFU read, single beat.
    do_reset();
    ifu_m2s.arvalid = 1'b1; ifu_m2s.araddr = 32'h3000_0000; ifu_m2s.arsize = 3'd2;
    ifu_m2s.rready = 1'b1;
    at_mid();
    check("solo_c0_ifu_arready", 64'(ifu_s2m.arready), 64'(1));
    check("solo_c0_lsu_arready", 64'(lsu_s2m.arready), 64'(0));
    next_cycle();
    ifu_m2s.arvalid = 1'b0;
    at_mid();
    check("solo_c1_mem_arvalid", 64'(mem_m2s.arvalid), 64'(1));
    check("solo_c1_mem_araddr", 64'(mem_m2s.araddr), 64'(32'h3000_0000));
    next_cycle();
    mem_s2m.arready = 1'b1;
    at_mid();
    check("solo_c2_mem_arvalid", 64'(mem_m2s.arvalid), 64'(1));
    next_cycle();
    mem_s2m.arready = 1'b0;
    at_mid();
    check("solo_c3_busy", 64'(busy), 64'(1));
    next_cycle();
    mem_s2m.rvalid = 1'b1; mem_s2m.rlast = 1'b1; mem_s2m.rdata = 32'h0000_0013;
    at_mid();
    check("solo_c4_ifu_rvalid", 64'(ifu_s2m.rvalid), 64'(1));
    check("solo_c4_ifu_rdata", 64'(ifu_s2m.rdata), 64'(32'h13));
    check("solo_c4_lsu_rvalid", 64'(lsu_s2m.rvalid), 64'(0));
    next_cycle();
    mem_s2m = '0;
    at_mid();
    check("solo_c5_busy", 64'(busy), 64'(0));
    next_cycle();

    // Contention: both request every cycle, memory answers immediately.
    do_reset();
    ifu_m2s.arvalid = 1'b1; ifu_m2s.araddr = 32'h1000; ifu_m2s.rready = 1'b1;
    lsu_m2s.arvalid = 1'b1; lsu_m2s.araddr = 32'h2000; lsu_m2s.rready = 1'b1;
    mem_s2m.arready = 1'b1; mem_s2m.rvalid = 1'b1; mem_s2m.rlast = 1'b1; mem_s2m.rdata = 32'h77;
    ngr = 0;
    for (int i = 0; i < 4; i++) begin
      gr_who[i] = -1;
      gr_cyc[i] = -1;
    end
    for (int c = 0; c < 12; c++) begin
      at_mid();
      if (ifu_s2m.arready) begin
        if (ngr < 4) begin gr_who[ngr] = 0; gr_cyc[ngr] = c; end
        ngr++;
      end
      if (lsu_s2m.arready) begin
        if (ngr < 4) begin gr_who[ngr] = 1; gr_cyc[ngr] = c; end
        ngr++;
      end
      next_cycle();
    end
    check("rr_grant_count", 64'(ngr), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d_who", i), 64'(gr_who[i]), 64'(i % 2));
      check($sformatf("rr_grant%0d_cycle", i), 64'(gr_cyc[i]), 64'(3 * i));
    end

    // Burst lock: LSU 4-beat burst while IFU keeps requesting.
    do_reset();
    lsu_m2s.arvalid = 1'b1; lsu_m2s.araddr = 32'h4000; lsu_m2s.arlen = 8'd3; lsu_m2s.rready = 1'b1;
    at_mid();
    check("lock_c0_lsu_arready", 64'(lsu_s2m.arready), 64'(1));
    next_cycle();
    lsu_m2s.arvalid = 1'b0;
    ifu_m2s.arvalid = 1'b1; ifu_m2s.araddr = 32'h5000; ifu_m2s.rready = 1'b1;
    mem_s2m.arready = 1'b1;
    at_mid();
    check("lock_c1_ifu_arready", 64'(ifu_s2m.arready), 64'(0));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      mem_s2m = '0;
      mem_s2m.rvalid = 1'b1; mem_s2m.rdata = 32'hA0 + 32'(k); mem_s2m.rlast = (k == 3);
      at_mid();
      check($sformatf("lock_beat%0d_lsu_rvalid", k), 64'(lsu_s2m.rvalid), 64'(1));
      check($sformatf("lock_beat%0d_lsu_rdata", k), 64'(lsu_s2m.rdata), 64'(32'hA0 + k));
      check($sformatf("lock_beat%0d_ifu_arready", k), 64'(ifu_s2m.arready), 64'(0));
      next_cycle();
    end
    mem_s2m = '0;
    at_mid();
    check("lock_after_ifu_arready", 64'(ifu_s2m.arready), 64'(1));
    next_cycle();

    // Flush mid-burst: IFU 4-beat burst, flush after beat 1.
    do_reset();
    ifu_m2s.arvalid = 1'b1; ifu_m2s.araddr = 32'h6000; ifu_m2s.arlen = 8'd3; ifu_m2s.rready = 1'b1;
    next_cycle();
    ifu_m2s.arvalid = 1'b0;
    mem_s2m.arready = 1'b1;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      mem_s2m = '0;
      mem_s2m.rvalid = 1'b1; mem_s2m.rdata = 32'hB0 + 32'(k);
      at_mid();
      check($sformatf("flush_beat%0d_ifu_rvalid", k), 64'(ifu_s2m.rvalid), 64'(1));
      next_cycle();
    end
    mem_s2m = '0;
    ifu_flush = 1'b1;
    ifu_m2s.rready = 1'b0;
    next_cycle();
    ifu_flush = 1'b0;
    for (int k = 2; k < 4; k++) begin
      mem_s2m.rvalid = 1'b1; mem_s2m.rdata = 32'hB0 + 32'(k); mem_s2m.rlast = (k == 3);
      at_mid();
      check($sformatf("flush_beat%0d_ifu_rvalid", k), 64'(ifu_s2m.rvalid), 64'(0));
      check($sformatf("flush_beat%0d_mem_rready", k), 64'(mem_m2s.rready), 64'(1));
      next_cycle();
    end
    mem_s2m = '0;
    at_mid();
    check("flush_after_busy", 64'(busy), 64'(0));
    next_cycle();

    // Flush in IDLE blocks the IFU request; flush during LSU read is ignored.
    do_reset();
    ifu_m2s.arvalid = 1'b1;
    ifu_flush = 1'b1;
    at_mid();
    check("fidle_c0_ifu_arready", 64'(ifu_s2m.arready), 64'(0));
    next_cycle();
    ifu_m2s.arvalid = 1'b0;
    ifu_flush = 1'b0;
    lsu_m2s.arvalid = 1'b1; lsu_m2s.araddr = 32'h7000; lsu_m2s.rready = 1'b1;
    at_mid();
    check("fidle_c1_mem_arvalid", 64'(mem_m2s.arvalid), 64'(0));
    check("fidle_c1_busy", 64'(busy), 64'(0));
    next_cycle();
    lsu_m2s.arvalid = 1'b0;
    mem_s2m.arready = 1'b1;
    next_cycle();
    mem_s2m = '0;
    mem_s2m.rvalid = 1'b1; mem_s2m.rlast = 1'b1; mem_s2m.rdata = 32'h55;
    ifu_flush = 1'b1;
    at_mid();
    check("flsu_lsu_rvalid", 64'(lsu_s2m.rvalid), 64'(1));
    check("flsu_lsu_rdata", 64'(lsu_s2m.rdata), 64'(32'h55));
    check("flsu_mem_rready", 64'(mem_m2s.rready), 64'(1));
    next_cycle();
    ifu_flush = 1'b0;
    mem_s2m = '0;
    at_mid();
    check("flsu_after_busy", 64'(busy), 64'(0));
    next_cycle();

    // Reset during an LSU data beat, with prio pointing at LSU beforehand.
    do_reset();
    ifu_m2s.arvalid = 1'b1; ifu_m2s.rready = 1'b1;
    next_cycle();
    ifu_m2s.arvalid = 1'b0;
    mem_s2m.arready = 1'b1;
    next_cycle();
    mem_s2m = '0;
    mem_s2m.rvalid = 1'b1; mem_s2m.rlast = 1'b1; mem_s2m.rdata = 32'h1;
    next_cycle();
    mem_s2m = '0;
    lsu_m2s.arvalid = 1'b1; lsu_m2s.araddr = 32'h8000; lsu_m2s.arlen = 8'd3; lsu_m2s.rready = 1'b1;
    at_mid();
    check("rst_lsu_arready", 64'(lsu_s2m.arready), 64'(1));
    next_cycle();
    lsu_m2s.arvalid = 1'b0;
    mem_s2m.arready = 1'b1;
    next_cycle();
    mem_s2m = '0;
    mem_s2m.rvalid = 1'b1; mem_s2m.rdata = 32'hC0;
    reset = 1'b1;
    at_mid();
    check("rst_pre_owner", 64'(owner), 64'(1));
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    at_mid();
    check_reset_outputs("rst_data");
    next_cycle();
    ifu_m2s.arvalid = 1'b1;
    lsu_m2s.arvalid = 1'b1;
    at_mid();
    check("rst_prio_ifu_arready", 64'(ifu_s2m.arready), 64'(1));
    check("rst_prio_lsu_arready", 64'(lsu_s2m.arready), 64'(0));
    next_cycle();

    // Randomized traffic against a reactive memory responder.
    do_reset();
    beats = 0;
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 599) == 0);
      ifu_flush = ($urandom_range(0, 7) == 0);
      ifu_m2s   = rand_req();
      lsu_m2s   = rand_req();
      mem_s2m   = '0;
      mem_s2m.arready = 1'($urandom_range(0, 1));
      if (beats > 0 && $urandom_range(0, 3) != 0) begin
        mem_s2m.rvalid = 1'b1;
        mem_s2m.rdata  = $urandom;
        mem_s2m.rresp  = 2'($urandom_range(0, 3));
        mem_s2m.rid    = 4'($urandom_range(0, 15));
        mem_s2m.rlast  = (beats == 1);
      end
      at_mid();
      if (reset) begin
        beats = 0;
      end else if (mem_m2s.arvalid && mem_s2m.arready) begin
        beats = int'(mem_m2s.arlen) + 1;
      end else if (mem_s2m.rvalid && mem_m2s.rready) begin
        beats--;
      end
      next_cycle();
    end

    reset = 1'b0;
    idle_inputs();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
